// File: rtl/pkt_ingress_writer.sv
// Ingress writer in front of the packet buffer FIFO: writes framed beats speculatively and
// publishes a committed write pointer only for whole, accepted frames; rejected frames are rewound.
module pkt_ingress_writer #(
  parameter int ADDR_WIDTH = 11,
  parameter int W_EL       = 8,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1518,
  parameter int W_LEN      = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W_EL-1:0]       in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_drop,
  output logic [W_EL-1:0]       fifo_wdata,
  output logic                  fifo_wen,
  input  logic                  fifo_full,
  output logic                  fifo_wrst,
  output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
  output logic [ADDR_WIDTH:0]   commit_wptr,
  output logic                  frame_valid,
  output logic [W_LEN-1:0]      frame_len,
  output logic [31:0]           cnt_pass,
  output logic [31:0]           cnt_drop,
  output logic [15:0]           cnt_err
);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD, REWIND} state_t;

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [W_LEN-1:0]    LEN_ONE = {{(W_LEN-1){1'b0}}, 1'b1};
  localparam logic [W_LEN-1:0]    MIN_L   = W_LEN'(MIN_LEN);
  localparam logic [W_LEN-1:0]    MAX_L   = W_LEN'(MAX_LEN);

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   wr_ptr_after;
  logic [W_LEN-1:0]      len;
  logic [W_LEN-1:0]      len_after;
  logic                  beat;
  logic                  write_beat;
  logic                  start_frame;
  logic                  commit;
  logic                  err;

  assign in_ready      = !reset && (state != REWIND);
  assign beat          = in_valid && in_ready;
  assign fifo_wdata    = in_data;
  assign fifo_wen      = write_beat;
  assign fifo_wrst     = !reset && (state == REWIND);
  assign fifo_rst_wptr = commit_wptr;

  // A frame always starts right after the committed pointer, so stale shadow state is never reused.
  always_comb begin
    state_next   = state;
    write_beat   = 1'b0;
    start_frame  = 1'b0;
    commit       = 1'b0;
    err          = 1'b0;
    len_after    = len + LEN_ONE;
    wr_ptr_after = wr_ptr + PTR_ONE;
    case (state)
      IDLE: begin
        if (beat) begin
          if (!in_sop) begin
            err = 1'b1;
          end else if (fifo_full) begin
            state_next = in_eop ? REWIND : DISCARD;
          end else begin
            write_beat   = 1'b1;
            start_frame  = 1'b1;
            len_after    = LEN_ONE;
            wr_ptr_after = commit_wptr + PTR_ONE;
            state_next   = RECV;
            if (in_eop) begin
              if (in_drop || (len_after < MIN_L)) state_next = REWIND;
              else begin
                commit     = 1'b1;
                state_next = IDLE;
              end
            end
          end
        end
      end
      RECV: begin
        if (beat) begin
          if (in_sop) begin
            err        = 1'b1;
            state_next = REWIND;
          end else if (fifo_full || (len == MAX_L)) begin
            state_next = in_eop ? REWIND : DISCARD;
          end else begin
            write_beat = 1'b1;
            if (in_eop) begin
              if (in_drop || (len_after < MIN_L)) state_next = REWIND;
              else begin
                commit     = 1'b1;
                state_next = IDLE;
              end
            end
          end
        end
      end
      DISCARD: begin
        if (beat) begin
          if (in_sop) begin
            err        = 1'b1;
            state_next = REWIND;
          end else if (in_eop) begin
            state_next = REWIND;
          end
        end
      end
      REWIND:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      len         <= '0;
      commit_wptr <= '0;
      frame_len   <= '0;
      frame_valid <= 1'b0;
      cnt_pass    <= '0;
      cnt_drop    <= '0;
      cnt_err     <= '0;
    end else begin
      state       <= state_next;
      frame_valid <= commit;
      if (write_beat) begin
        wr_ptr <= wr_ptr_after;
        len    <= len_after;
      end
      if (commit) begin
        commit_wptr <= wr_ptr_after;
        frame_len   <= len_after;
        cnt_pass    <= cnt_pass + 32'd1;
      end
      if (state == REWIND) begin
        wr_ptr   <= commit_wptr;
        len      <= '0;
        cnt_drop <= cnt_drop + 32'd1;
      end
      if (err && (cnt_err != 16'hFFFF)) cnt_err <= cnt_err + 16'd1;
    end
  end

endmodule

// File: tb/tb_pkt_ingress_writer.sv
// Randomised bench for pkt_ingress_writer: a frame-level reference model predicts every output
// each cycle, and a few hand-computed checkpoints pin the model itself.
module tb_pkt_ingress_writer;

  localparam int ADDR_WIDTH = 11;
  localparam int W_EL       = 8;
  localparam int MIN_LEN    = 60;
  localparam int MAX_LEN    = 1518;
  localparam int W_LEN      = 11;
  localparam int PTR_MOD    = 1 << (ADDR_WIDTH + 1);
  localparam int NO_IDX     = 1000000;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [W_EL-1:0]     in_data;
  logic                in_sop;
  logic                in_eop;
  logic                in_drop;
  logic [W_EL-1:0]     fifo_wdata;
  logic                fifo_wen;
  logic                fifo_full;
  logic                fifo_wrst;
  logic [ADDR_WIDTH:0] fifo_rst_wptr;
  logic [ADDR_WIDTH:0] commit_wptr;
  logic                frame_valid;
  logic [W_LEN-1:0]    frame_len;
  logic [31:0]         cnt_pass;
  logic [31:0]         cnt_drop;
  logic [15:0]         cnt_err;

  int errors = 0;
  int checks = 0;

  pkt_ingress_writer #(
    .ADDR_WIDTH(ADDR_WIDTH), .W_EL(W_EL), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .W_LEN(W_LEN)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_drop(in_drop), .fifo_wdata(fifo_wdata),
    .fifo_wen(fifo_wen), .fifo_full(fifo_full), .fifo_wrst(fifo_wrst),
    .fifo_rst_wptr(fifo_rst_wptr), .commit_wptr(commit_wptr), .frame_valid(frame_valid),
    .frame_len(frame_len), .cnt_pass(cnt_pass), .cnt_drop(cnt_drop), .cnt_err(cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: tracks the open frame by beats written and whether it has been spoiled.
  bit started = 0;
  bit m_in_frame = 0;
  bit m_spoiled = 0;
  bit m_rewind = 0;
  bit m_fv = 0;
  int m_beats = 0;
  int m_commit = 0;
  int m_len = 0;
  longint m_pass = 0;
  longint m_drop = 0;
  int m_err = 0;

  always @(negedge clk) begin
    bit e_ready, e_wrst, e_wen, acc;
    e_ready = !reset && !m_rewind;
    e_wrst  = !reset && m_rewind;
    acc     = in_valid && e_ready;
    e_wen   = 1'b0;
    if (acc) begin
      if (!m_in_frame)     e_wen = in_sop && !fifo_full;
      else if (!m_spoiled) e_wen = !in_sop && !fifo_full && (m_beats < MAX_LEN);
    end
    if (started) begin
      checkOutput("in_ready", 64'(in_ready), 64'(e_ready));
      checkOutput("fifo_wen", 64'(fifo_wen), 64'(e_wen));
      checkOutput("fifo_wrst", 64'(fifo_wrst), 64'(e_wrst));
      checkOutput("fifo_wdata", 64'(fifo_wdata), 64'(in_data));
      checkOutput("fifo_rst_wptr", 64'(fifo_rst_wptr), 64'(m_commit));
      checkOutput("commit_wptr", 64'(commit_wptr), 64'(m_commit));
      checkOutput("frame_valid", 64'(frame_valid), 64'(m_fv));
      checkOutput("frame_len", 64'(frame_len), 64'(m_len));
      checkOutput("cnt_pass", 64'(cnt_pass), 64'(m_pass % 64'h1_0000_0000));
      checkOutput("cnt_drop", 64'(cnt_drop), 64'(m_drop % 64'h1_0000_0000));
      checkOutput("cnt_err", 64'(cnt_err), 64'(m_err));
    end
    m_fv = 1'b0;
    if (reset) begin
      started = 1; m_in_frame = 0; m_spoiled = 0; m_rewind = 0; m_beats = 0;
      m_commit = 0; m_len = 0; m_pass = 0; m_drop = 0; m_err = 0;
    end else if (m_rewind) begin
      m_rewind = 0;
      m_drop++;
    end else if (acc) begin
      if ((in_sop && m_in_frame) || (!in_sop && !m_in_frame)) begin
        if (m_err < 65535) m_err++;
        if (m_in_frame) begin
          m_in_frame = 0;
          m_rewind   = 1;
        end
      end else begin
        if (in_sop) begin
          m_in_frame = 1; m_spoiled = 0; m_beats = 0;
        end
        if (e_wen) m_beats++;
        else       m_spoiled = 1;
        if (in_eop) begin
          m_in_frame = 0;
          if (m_spoiled || in_drop || (m_beats < MIN_LEN)) m_rewind = 1;
          else begin
            m_commit = (m_commit + m_beats) % PTR_MOD;
            m_len    = m_beats;
            m_fv     = 1;
            m_pass++;
          end
        end
      end
    end
  end

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b0;
      in_data   = 8'($urandom);
      in_drop   = 1'($urandom);
      fifo_full = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Presents one beat and holds it until accepted, within a bounded number of cycles.
  task automatic applyStimulus(input bit sop, input bit eop, input bit drop, input bit full);
    bit accepted;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    in_sop    = sop;
    in_eop    = eop;
    in_drop   = eop ? drop : 1'($urandom);
    fifo_full = full;
    accepted  = 1'b0;
    for (int t = 0; t < 16 && !accepted; t++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk); #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 16 cycles expected acceptance at %0t", $time);
    end
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic sendFrame(input int len, input bit drop, input int sop_at, input int full_from, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) idleCycles(1);
      applyStimulus((i == 0) || (i == sop_at), i == len - 1, drop, i >= full_from);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    in_drop = 1'b0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_commit_wptr", 64'(commit_wptr), 64'd0);
    checkOutput("reset_cnt_pass", 64'(cnt_pass), 64'd0);
    idleCycles(2);

    sendFrame(64, 0, NO_IDX, NO_IDX, 0);
    checkOutput("t1_frame_valid", 64'(frame_valid), 64'd1);
    idleCycles(2);
    checkOutput("t1_commit_wptr", 64'(commit_wptr), 64'd64);
    checkOutput("t1_frame_len", 64'(frame_len), 64'd64);
    checkOutput("t1_cnt_pass", 64'(cnt_pass), 64'd1);

    sendFrame(100, 1, NO_IDX, NO_IDX, 0);
    checkOutput("t2_fifo_wrst", 64'(fifo_wrst), 64'd1);
    checkOutput("t2_rst_wptr", 64'(fifo_rst_wptr), 64'd64);
    idleCycles(2);
    checkOutput("t2_cnt_drop", 64'(cnt_drop), 64'd1);
    checkOutput("t2_commit_wptr", 64'(commit_wptr), 64'd64);

    sendFrame(40, 0, NO_IDX, NO_IDX, 1);
    idleCycles(2);
    checkOutput("t3_cnt_drop", 64'(cnt_drop), 64'd2);
    checkOutput("t3_cnt_pass", 64'(cnt_pass), 64'd1);

    sendFrame(80, 0, NO_IDX, 30, 1);
    idleCycles(2);
    checkOutput("t4_cnt_drop", 64'(cnt_drop), 64'd3);
    checkOutput("t4_commit_wptr", 64'(commit_wptr), 64'd64);

    sendFrame(11, 0, 10, NO_IDX, 0);
    applyStimulus(0, 0, 0, 0);
    sendFrame(60, 0, NO_IDX, NO_IDX, 0);
    idleCycles(2);
    checkOutput("t5_cnt_err", 64'(cnt_err), 64'd2);
    checkOutput("t5_cnt_drop", 64'(cnt_drop), 64'd4);
    checkOutput("t5_commit_wptr", 64'(commit_wptr), 64'd124);

    sendFrame(MAX_LEN, 0, NO_IDX, NO_IDX, 0);
    idleCycles(2);
    checkOutput("max_frame_len", 64'(frame_len), 64'd1518);
    checkOutput("max_commit_wptr", 64'(commit_wptr), 64'd1642);
    sendFrame(MAX_LEN + 5, 0, NO_IDX, NO_IDX, 0);
    idleCycles(2);
    checkOutput("over_cnt_drop", 64'(cnt_drop), 64'd5);
    checkOutput("over_commit_wptr", 64'(commit_wptr), 64'd1642);
    sendFrame(MIN_LEN, 0, NO_IDX, NO_IDX, 0);
    idleCycles(2);
    checkOutput("min_commit_wptr", 64'(commit_wptr), 64'd1702);

    // Random traffic long enough to carry the pointer across its wrap.
    for (int f = 0; f < 120; f++) begin
      int len, sop_at, full_from;
      len       = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 70) : $urandom_range(55, 200);
      sop_at    = ($urandom_range(0, 12) == 0) ? $urandom_range(1, 200) : NO_IDX;
      full_from = ($urandom_range(0, 12) == 0) ? $urandom_range(0, 200) : NO_IDX;
      sendFrame(len, $urandom_range(0, 5) == 0, sop_at, full_from, 1);
      if ($urandom_range(0, 15) == 0) applyStimulus(0, 1'($urandom), 0, 0);
      idleCycles($urandom_range(0, 3));
    end

    sendFrame(64, 0, NO_IDX, NO_IDX, 0);
    idleCycles(2);
    checkOutput("wrap_frame_len", 64'(frame_len), 64'd64);

    for (int i = 0; i < 30; i++) applyStimulus(i == 0, 0, 0, 0);
    reset = 1'b1;
    idleCycles(2);
    reset = 1'b0;
    checkOutput("midreset_commit_wptr", 64'(commit_wptr), 64'd0);
    checkOutput("midreset_cnt_pass", 64'(cnt_pass), 64'd0);
    checkOutput("midreset_cnt_drop", 64'(cnt_drop), 64'd0);
    checkOutput("midreset_cnt_err", 64'(cnt_err), 64'd0);
    checkOutput("midreset_frame_len", 64'(frame_len), 64'd0);

    sendFrame(70, 0, NO_IDX, NO_IDX, 1);
    idleCycles(2);
    checkOutput("post_reset_commit_wptr", 64'(commit_wptr), 64'd70);
    checkOutput("post_reset_cnt_pass", 64'(cnt_pass), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
